// File: rtl/mic3_level_meter.sv
// Level meter for the Pmod MIC3 sample stream: offset removal, magnitude,
// per-window peak/average/clip statistics and a decaying peak-hold value.
module mic3_level_meter #(
    parameter int WINDOW_LOG2  = 8,
    parameter int HOLD_WINDOWS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] audio,
    input  logic        new_data,
    input  logic        clear,
    output logic [11:0] sample_s,
    output logic        sample_valid,
    output logic [10:0] peak,
    output logic [10:0] avg,
    output logic        clip,
    output logic [10:0] peak_hold,
    output logic        level_valid
);

    localparam int SW = 11 + WINDOW_LOG2;
    localparam int HW = $clog2(HOLD_WINDOWS + 1);
    localparam logic [HW-1:0]          HOLD_LOAD = HW'(HOLD_WINDOWS);
    localparam logic [WINDOW_LOG2-1:0] LAST_IDX  = '1;

    logic                   s1_clip;
    logic [10:0]            mag;
    logic                   s2_valid;
    logic                   s2_clip;
    logic [SW-1:0]          sum;
    logic [10:0]            run_peak;
    logic                   clip_sticky;
    logic [WINDOW_LOG2-1:0] count;
    logic [HW-1:0]          hold_cnt;

    logic [11:0]            neg_s;
    logic [10:0]            mag_abs;
    logic [SW-1:0]          sum_next;
    logic [10:0]            peak_next;
    logic                   clip_next;

    assign neg_s = (~sample_s) + 12'd1;

    // -2048 has no positive 11-bit counterpart, so it saturates to 2047
    always_comb begin
        mag_abs = sample_s[10:0];
        if (sample_s == 12'h800)
            mag_abs = 11'h7FF;
        else if (sample_s[11])
            mag_abs = neg_s[10:0];
    end

    always_comb begin
        sum_next  = sum + SW'(mag);
        peak_next = (mag > run_peak) ? mag : run_peak;
        clip_next = clip_sticky | s2_clip;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sample_s     <= '0;
            sample_valid <= 1'b0;
            s1_clip      <= 1'b0;
            mag          <= '0;
            s2_valid     <= 1'b0;
            s2_clip      <= 1'b0;
            sum          <= '0;
            run_peak     <= '0;
            clip_sticky  <= 1'b0;
            count        <= '0;
            peak         <= '0;
            avg          <= '0;
            clip         <= 1'b0;
            peak_hold    <= '0;
            hold_cnt     <= '0;
            level_valid  <= 1'b0;
        end else begin
            level_valid <= 1'b0;
            if (clear) begin
                sample_valid <= 1'b0;
                s2_valid     <= 1'b0;
                sum          <= '0;
                run_peak     <= '0;
                clip_sticky  <= 1'b0;
                count        <= '0;
            end else begin
                sample_valid <= new_data;
                if (new_data) begin
                    sample_s <= {~audio[11], audio[10:0]};
                    s1_clip  <= (audio == 12'd0) || (audio == 12'hFFF);
                end

                s2_valid <= sample_valid;
                if (sample_valid) begin
                    mag     <= mag_abs;
                    s2_clip <= s1_clip;
                end

                if (s2_valid) begin
                    if (count == LAST_IDX) begin
                        // Close the window and restart accumulation in the same cycle
                        peak        <= peak_next;
                        avg         <= sum_next[SW-1:WINDOW_LOG2];
                        clip        <= clip_next;
                        level_valid <= 1'b1;
                        sum         <= '0;
                        run_peak    <= '0;
                        clip_sticky <= 1'b0;
                        count       <= '0;
                        if ((peak_next >= peak_hold) || (hold_cnt == '0)) begin
                            peak_hold <= peak_next;
                            hold_cnt  <= HOLD_LOAD;
                        end else begin
                            hold_cnt  <= hold_cnt - HW'(1);
                        end
                    end else begin
                        sum         <= sum_next;
                        run_peak    <= peak_next;
                        clip_sticky <= clip_next;
                        count       <= count + WINDOW_LOG2'(1);
                    end
                end
            end
        end
    end

endmodule

// File: doc/mic3_level_meter.md
Name: mic3_level_meter

Overview:
- Downstream consumer of the Pmod MIC3 interface.
- Takes each unsigned 12-bit microphone sample and its one-cycle new-data strobe, removes the mid-scale offset, and computes per-window level statistics.
- Statistics per window of 2^WINDOW_LOG2 samples: peak magnitude, average magnitude, clip flag, and a peak-hold value for the level display / LED bar logic.
- Fully pipelined; accepts a sample on every clock cycle.

Parameters:
- WINDOW_LOG2, 8, log2 of samples per window; legal range 1..16.
- HOLD_WINDOWS, 4, number of extra windows peak_hold is retained before it may decay; minimum 1.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- audio  input  12  unsigned sample from the MIC3 interface; valid only while new_data=1.
- new_data  input  1  one-cycle sample strobe; may be high on consecutive cycles.
- clear  input  1  synchronous: discards the partial window and in-flight samples.
- sample_s  output  12  signed, offset-removed sample (two's complement).
- sample_valid  output  1  one-cycle strobe qualifying sample_s.
- peak  output  11  maximum magnitude in the last completed window.
- avg  output  11  mean magnitude of the last completed window, truncated.
- clip  output  1  1 if the last completed window contained audio=0 or audio=4095.
- peak_hold  output  11  held peak, see decay rule below.
- level_valid  output  1  one-cycle strobe when peak/avg/clip/peak_hold update.

Behaviour:
Reset:
- On rst=1, all outputs, pipeline valids, accumulator, window counter, running peak, clip sticky and hold counter go to 0.
- rst mid-window abandons the window; no level_valid is issued for it.

Pipeline (sample presented at cycle T with new_data=1):
- T+1: sample_s = audio - 2048 (equivalent to inverting audio[11]); sample_valid=1. Otherwise sample_valid=0 and sample_s holds its value.
- T+2 (internal): mag = |sample_s|, saturated to 2047, so -2048 gives 2047. An internal clip bit is registered, set when audio was 0 or 4095.
- T+3: window update:
  - sum += mag, with sum width 11+WINDOW_LOG2 so it never overflows.
  - run_peak = max(run_peak, mag).
  - clip_sticky |= clip bit.
  - count += 1, with count WINDOW_LOG2 bits wide.

Window close (at T+3 of the sample with count = 2^WINDOW_LOG2-1):
- peak <= max(run_peak, mag).
- avg <= (sum+mag) >> WINDOW_LOG2.
- clip <= clip_sticky | clip bit.
- level_valid = 1 for that cycle.
- sum, run_peak, clip_sticky and count are all reset to 0 in the same cycle, so back-to-back windows lose no sample.

Peak hold (evaluated on the window-close cycle, using the new peak value P):
- If P >= peak_hold or hold_cnt == 0: peak_hold <= P, hold_cnt <= HOLD_WINDOWS.
- Otherwise: hold_cnt <= hold_cnt - 1 and peak_hold is unchanged.
- hold_cnt width is clog2(HOLD_WINDOWS+1).

clear:
- Zeroes sum, run_peak, clip_sticky, count and all internal pipeline valids (sample_valid included) in the next cycle.
- peak, avg, clip, peak_hold, hold_cnt and sample_s retain their values.
- clear and new_data in the same cycle: clear wins and the sample is dropped.
- Samples already in the pipeline when clear is asserted are discarded.

Outputs between strobes:
- All outputs are registered.
- level outputs are stable between level_valid strobes.

Test Plan:
- Reset: rst=1 for 2 cycles with random audio/new_data -> all outputs 0, no strobes for 4 cycles after release.
- Offset and saturation: audio 2048, 4095, 0, 1 on separate strobes -> sample_s 0x000, 0x7FF, 0x800, 0x801 each at T+1; internal mags 0, 2047, 2047, 2047.
- Window stats (WINDOW_LOG2=2): audio 2148, 1948, 2548, 2048 -> level_valid exactly 3 cycles after the 4th strobe, with peak=500, avg=175 ((100+100+500+0)/4), clip=0. Repeat with 0 as the 4th sample -> peak=2047, clip=1.
- Throughput (WINDOW_LOG2=2): new_data high for 8 consecutive cycles -> exactly two level_valid pulses, 4 cycles apart, with correct sums and no dropped sample.
- Peak hold (HOLD_WINDOWS=2): window peaks 500, 100, 100, 100, 600 -> peak_hold 500, 500, 500, 100, 600.
- clear / reset mid-window (WINDOW_LOG2=2): 2 samples, clear, then 4 samples of 2248 -> single level_valid with peak=200, avg=200. The same sequence with rst in place of clear -> same result, and peak_hold restarts from 0.
